// File: rtl/load_store_unit.sv
// Load/store unit: computes the D/DS-form effective address, holds the data-memory
// port for MEM_LATENCY cycles, formats load data and hands it to writeback.
module load_store_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [63:0] req_base,
    input  logic [15:0] req_disp,
    input  logic [63:0] req_store_data,
    input  logic [4:0]  req_rt,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic [5:0]  mem_opcode,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_read_data,
    output logic        wb_valid,
    output logic [63:0] wb_data,
    output logic [4:0]  wb_rt,
    input  logic        wb_ready,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [5:0]  op_q;
    logic [63:0] data_q;
    logic [63:0] ea_q;
    logic [4:0]  rt_q;
    logic        load_q;

    logic        is_load;
    logic        is_store;
    logic        ds_form;
    logic [63:0] disp_ext;
    logic [63:0] ea_next;
    logic [63:0] load_fmt;

    always_comb begin
        is_load  = (req_opcode == 6'd32) || (req_opcode == 6'd34) || (req_opcode == 6'd40) ||
                   (req_opcode == 6'd42) || (req_opcode == 6'd58);
        is_store = (req_opcode == 6'd36) || (req_opcode == 6'd38) || (req_opcode == 6'd44) ||
                   (req_opcode == 6'd62);
        ds_form  = (req_opcode == 6'd58) || (req_opcode == 6'd62);
        disp_ext = {{48{req_disp[15]}}, req_disp[15:2], ds_form ? 2'b00 : req_disp[1:0]};
        ea_next  = req_base + disp_ext;
    end

    always_comb begin
        load_fmt = mem_read_data;
        case (op_q)
            6'd34:   load_fmt = {56'd0, mem_read_data[7:0]};
            6'd40:   load_fmt = {48'd0, mem_read_data[15:0]};
            6'd42:   load_fmt = {{48{mem_read_data[15]}}, mem_read_data[15:0]};
            6'd32:   load_fmt = {32'd0, mem_read_data[31:0]};
            default: load_fmt = mem_read_data;
        endcase
    end

    assign req_ready = (state == IDLE);

    // The first ACCESS cycle loads the port registers; the strobes are then held for
    // MEM_LATENCY cycles and read data is captured on the edge that ends the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            op_q           <= 6'd0;
            data_q         <= 64'd0;
            ea_q           <= 64'd0;
            rt_q           <= 5'd0;
            load_q         <= 1'b0;
            mem_address    <= 64'd0;
            mem_write_data <= 64'd0;
            mem_opcode     <= 6'd0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            wb_valid       <= 1'b0;
            wb_data        <= 64'd0;
            wb_rt          <= 5'd0;
            err            <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (is_load || is_store) begin
                            op_q   <= req_opcode;
                            data_q <= req_store_data;
                            rt_q   <= req_rt;
                            ea_q   <= ea_next;
                            load_q <= is_load;
                            cnt    <= 4'(MEM_LATENCY);
                            state  <= ACCESS;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        mem_address    <= ea_q;
                        mem_write_data <= data_q;
                        mem_opcode     <= op_q;
                        mem_read       <= load_q;
                        mem_write      <= !load_q;
                        cnt            <= cnt - 4'd1;
                    end else begin
                        mem_address    <= 64'd0;
                        mem_write_data <= 64'd0;
                        mem_opcode     <= 6'd0;
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        if (load_q) begin
                            wb_valid <= 1'b1;
                            wb_data  <= load_fmt;
                            wb_rt    <= rt_q;
                            state    <= RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RESP: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
